// File: rtl/mc_main_ctrl.sv
// ---------------------------------------------------------------------------
// mc_main_ctrl
// Multi-cycle main control FSM for the MIPS-subset CPU. Sequences each
// instruction through fetch/decode/execute/memory/writeback states over a
// shared ALU and a unified instruction/data memory, and stalls in the memory
// states until mem_ready_i.
//
// Ports:
//   clk_i, rst_i          clock (rising edge), async active-low reset
//   instr_op_i            opcode from IR[31:26]
//   zero_i                ALU zero flag (branch resolved in datapath)
//   mem_ready_i           memory access complete this cycle
//   pc_write_o .. alu_op_o  datapath control (Moore, from state)
//   state_o               current state, for debug
//   illegal_o             pulse in ID on an unsupported opcode
//   timeout_o             pulse when a memory wait hits MEM_WAIT_MAX
//
// Optional feature macro MC_PERF_CNT_EN: adds cyc_cnt_o / instr_cnt_o
// performance counters.
// ---------------------------------------------------------------------------
module mc_main_ctrl #(
    parameter int unsigned ST_W         = 4,
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [5:0]      instr_op_i,
    input  logic            zero_i,
    input  logic            mem_ready_i,
    output logic            pc_write_o,
    output logic            pc_write_cond_o,
    output logic            branch_ne_o,
    output logic [1:0]      pc_src_o,
    output logic            iord_o,
    output logic            mem_read_o,
    output logic            mem_write_o,
    output logic            ir_write_o,
    output logic            reg_write_o,
    output logic [1:0]      reg_dst_o,
    output logic [1:0]      mem_to_reg_o,
    output logic            alu_src_a_o,
    output logic [1:0]      alu_src_b_o,
    output logic [3:0]      alu_op_o,
    output logic [ST_W-1:0] state_o,
    output logic            illegal_o,
    output logic            timeout_o
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0]     cyc_cnt_o,
    output logic [31:0]     instr_cnt_o
`endif
);

    localparam logic [ST_W-1:0] S_IDLE = ST_W'(0);
    localparam logic [ST_W-1:0] S_IF   = ST_W'(1);
    localparam logic [ST_W-1:0] S_ID   = ST_W'(2);
    localparam logic [ST_W-1:0] S_EX   = ST_W'(3);
    localparam logic [ST_W-1:0] S_WB   = ST_W'(4);
    localparam logic [ST_W-1:0] S_ADDR = ST_W'(5);
    localparam logic [ST_W-1:0] S_MRD  = ST_W'(6);
    localparam logic [ST_W-1:0] S_MWB  = ST_W'(7);
    localparam logic [ST_W-1:0] S_MWR  = ST_W'(8);
    localparam logic [ST_W-1:0] S_BR   = ST_W'(9);
    localparam logic [ST_W-1:0] S_JMP  = ST_W'(10);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_SLTI = 6'h0A;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    // Counter only needs to hold 0..MEM_WAIT_MAX-1 before it wraps to 0.
    localparam int unsigned         WCNT_W    = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
    localparam bit                  TO_EN     = (MEM_WAIT_MAX != 0);
    localparam logic [WCNT_W-1:0]   WAIT_LAST = TO_EN ? WCNT_W'(MEM_WAIT_MAX - 1) : '0;

    logic [ST_W-1:0]   state, state_nxt;
    logic [WCNT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic              wait_st;

    // Branch condition is resolved in the datapath from pc_write_cond/branch_ne.
    logic unused_zero;
    assign unused_zero = zero_i;

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Memory wait counter
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) wait_cnt <= '0;
        else        wait_cnt <= wait_cnt_nxt;
    end

    assign wait_st = (state == S_IF) || (state == S_MRD) || (state == S_MWR);

    // Timeout fires on the wait cycle that would make the count reach the limit.
    always_comb begin
        timeout_o    = 1'b0;
        wait_cnt_nxt = '0;
        if (TO_EN && wait_st && !mem_ready_i && (wait_cnt == WAIT_LAST)) begin
            timeout_o = 1'b1;
        end
        if (wait_st && !mem_ready_i && !timeout_o && (state_nxt == state)) begin
            wait_cnt_nxt = wait_cnt + WCNT_W'(1);
        end
    end

    // Next-state and Moore output decode
    always_comb begin
        state_nxt       = state;
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        branch_ne_o     = 1'b0;
        pc_src_o        = 2'd0;
        iord_o          = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        ir_write_o      = 1'b0;
        reg_write_o     = 1'b0;
        reg_dst_o       = 2'd0;
        mem_to_reg_o    = 2'd0;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = 2'd0;
        alu_op_o        = 4'd0;
        illegal_o       = 1'b0;

        case (state)
            S_IDLE: state_nxt = S_IF;
            S_IF: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = 2'd1;
                alu_op_o    = 4'd15;
                if (mem_ready_i) begin
                    ir_write_o = 1'b1;
                    pc_write_o = 1'b1;
                    state_nxt  = S_ID;
                end
            end
            S_ID: begin
                alu_src_b_o = 2'd3;
                alu_op_o    = 4'd15;
                case (instr_op_i)
                    OP_R, OP_ADDI, OP_SLTI, OP_LUI, OP_ORI: state_nxt = S_EX;
                    OP_LW, OP_SW:                           state_nxt = S_ADDR;
                    OP_BEQ, OP_BNE:                         state_nxt = S_BR;
                    OP_J, OP_JAL:                           state_nxt = S_JMP;
                    default: begin
                        illegal_o = 1'b1;
                        state_nxt = S_IF;
                    end
                endcase
            end
            S_EX: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = (instr_op_i == OP_R) ? 2'd0 : 2'd2;
                case (instr_op_i)
                    OP_ADDI: alu_op_o = 4'd1;
                    OP_SLTI: alu_op_o = 4'd2;
                    OP_LUI:  alu_op_o = 4'd4;
                    OP_ORI:  alu_op_o = 4'd5;
                    default: alu_op_o = 4'd0;
                endcase
                state_nxt = S_WB;
            end
            S_WB: begin
                reg_write_o = 1'b1;
                reg_dst_o   = (instr_op_i == OP_R) ? 2'd1 : 2'd0;
                state_nxt   = S_IF;
            end
            S_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'd2;
                alu_op_o    = (instr_op_i == OP_LW) ? 4'd7 : 4'd8;
                state_nxt   = (instr_op_i == OP_LW) ? S_MRD : S_MWR;
            end
            S_MRD: begin
                mem_read_o = 1'b1;
                iord_o     = 1'b1;
                if (mem_ready_i) state_nxt = S_MWB;
            end
            S_MWB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 2'd1;
                state_nxt    = S_IF;
            end
            S_MWR: begin
                mem_write_o = 1'b1;
                iord_o      = 1'b1;
                if (mem_ready_i) state_nxt = S_IF;
            end
            S_BR: begin
                alu_src_a_o     = 1'b1;
                alu_op_o        = (instr_op_i == OP_BNE) ? 4'd6 : 4'd3;
                pc_write_cond_o = 1'b1;
                pc_src_o        = 2'd1;
                branch_ne_o     = (instr_op_i == OP_BNE);
                state_nxt       = S_IF;
            end
            S_JMP: begin
                pc_write_o = 1'b1;
                pc_src_o   = 2'd2;
                // JAL links the already-incremented PC into $31
                if (instr_op_i == OP_JAL) begin
                    reg_write_o  = 1'b1;
                    reg_dst_o    = 2'd2;
                    mem_to_reg_o = 2'd2;
                end
                state_nxt = S_IF;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign state_o = state;

`ifdef MC_PERF_CNT_EN
    logic retire_c;

    // An instruction retires when control returns to IF from a closing state.
    assign retire_c = (state_nxt == S_IF) &&
                      ((state == S_WB) || (state == S_MWB) || (state == S_MWR) ||
                       (state == S_BR) || (state == S_JMP) || (state == S_ID));

    // Performance counters
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cyc_cnt_o   <= '0;
            instr_cnt_o <= '0;
        end else begin
            if (state != S_IDLE) cyc_cnt_o   <= cyc_cnt_o + 32'd1;
            if (retire_c)        instr_cnt_o <= instr_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mc_main_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mc_main_ctrl
// Self-checking bench for mc_main_ctrl. A reference model expands each
// instruction (opcode plus chosen fetch/memory wait counts) into the list of
// per-cycle control vectors the controller must produce; the bench then plays
// those cycles against the DUT. Honours MC_PERF_CNT_EN when defined.
// ---------------------------------------------------------------------------
module tb_mc_main_ctrl;

    localparam int unsigned TB_ST_W     = 4;
    localparam int unsigned TB_WAIT_MAX = 15;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic       illegal;
        logic       timeout;
    } ctrl_t;

    typedef struct {
        logic       ready;
        logic [5:0] op;
        ctrl_t      exp;
        bit         idle;
        bit         retire;
    } step_t;

    logic clk_i = 1'b0;
    logic rst_i;
    logic [5:0] instr_op_i;
    logic zero_i;
    logic mem_ready_i;
    logic pc_write_o, pc_write_cond_o, branch_ne_o, iord_o, mem_read_o;
    logic mem_write_o, ir_write_o, reg_write_o, alu_src_a_o, illegal_o, timeout_o;
    logic [1:0] pc_src_o, reg_dst_o, mem_to_reg_o, alu_src_b_o;
    logic [3:0] alu_op_o;
    logic [TB_ST_W-1:0] state_o;
`ifdef MC_PERF_CNT_EN
    logic [31:0] cyc_cnt_o, instr_cnt_o;
`endif

    mc_main_ctrl #(.ST_W(TB_ST_W), .MEM_WAIT_MAX(TB_WAIT_MAX)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .instr_op_i(instr_op_i), .zero_i(zero_i),
        .mem_ready_i(mem_ready_i), .pc_write_o(pc_write_o),
        .pc_write_cond_o(pc_write_cond_o), .branch_ne_o(branch_ne_o),
        .pc_src_o(pc_src_o), .iord_o(iord_o), .mem_read_o(mem_read_o),
        .mem_write_o(mem_write_o), .ir_write_o(ir_write_o),
        .reg_write_o(reg_write_o), .reg_dst_o(reg_dst_o),
        .mem_to_reg_o(mem_to_reg_o), .alu_src_a_o(alu_src_a_o),
        .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o), .state_o(state_o),
        .illegal_o(illegal_o), .timeout_o(timeout_o)
`ifdef MC_PERF_CNT_EN
        , .cyc_cnt_o(cyc_cnt_o), .instr_cnt_o(instr_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    ctrl_t obs;
    always_comb obs = {pc_write_o, pc_write_cond_o, branch_ne_o, pc_src_o, iord_o,
                       mem_read_o, mem_write_o, ir_write_o, reg_write_o, reg_dst_o,
                       mem_to_reg_o, alu_src_a_o, alu_src_b_o, alu_op_o, illegal_o,
                       timeout_o};

    step_t       q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          step_no = 0;
    int unsigned m_cyc = 0;
    int unsigned m_instr = 0;
    logic [5:0]  legal_ops[10] = '{6'h00, 6'h08, 6'h0A, 6'h0F, 6'h0D,
                                   6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};

    function automatic void push(input logic rdy, input logic [5:0] op,
                                 input ctrl_t c, input bit idle, input bit ret);
        step_t s;
        s.ready = rdy; s.op = op; s.exp = c; s.idle = idle; s.retire = ret;
        q.push_back(s);
    endfunction

    function automatic bit to_hit(input int k);
        return (TB_WAIT_MAX != 0) && (((k + 1) % TB_WAIT_MAX) == 0);
    endfunction

    function automatic void push_idle();
        push(1'($urandom), 6'h00, '0, 1'b1, 1'b0);
    endfunction

    // Expand one instruction into its expected cycle sequence.
    function automatic void gen_instr(input logic [5:0] op, input int w_if, input int w_mem);
        ctrl_t c;
        bit    alu_c, mem_c, br_c, jmp_c;
        alu_c = (op == 6'h00) || (op == 6'h08) || (op == 6'h0A) || (op == 6'h0F) || (op == 6'h0D);
        mem_c = (op == 6'h23) || (op == 6'h2B);
        br_c  = (op == 6'h04) || (op == 6'h05);
        jmp_c = (op == 6'h02) || (op == 6'h03);
        // fetch: waits, then the ready cycle loads IR and PC
        for (int k = 0; k < w_if; k++) begin
            c = '0; c.mem_read = 1'b1; c.alu_src_b = 2'd1; c.alu_op = 4'd15;
            c.timeout = to_hit(k);
            push(1'b0, op, c, 1'b0, 1'b0);
        end
        c = '0; c.mem_read = 1'b1; c.alu_src_b = 2'd1; c.alu_op = 4'd15;
        c.ir_write = 1'b1; c.pc_write = 1'b1;
        push(1'b1, op, c, 1'b0, 1'b0);
        // decode
        c = '0; c.alu_src_b = 2'd3; c.alu_op = 4'd15;
        c.illegal = !(alu_c || mem_c || br_c || jmp_c);
        push(1'($urandom), op, c, 1'b0, c.illegal);
        if (alu_c) begin
            c = '0; c.alu_src_a = 1'b1; c.alu_src_b = (op == 6'h00) ? 2'd0 : 2'd2;
            case (op)
                6'h08:   c.alu_op = 4'd1;
                6'h0A:   c.alu_op = 4'd2;
                6'h0F:   c.alu_op = 4'd4;
                6'h0D:   c.alu_op = 4'd5;
                default: c.alu_op = 4'd0;
            endcase
            push(1'($urandom), op, c, 1'b0, 1'b0);
            c = '0; c.reg_write = 1'b1; c.reg_dst = (op == 6'h00) ? 2'd1 : 2'd0;
            push(1'($urandom), op, c, 1'b0, 1'b1);
        end else if (mem_c) begin
            c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'd2;
            c.alu_op = (op == 6'h23) ? 4'd7 : 4'd8;
            push(1'($urandom), op, c, 1'b0, 1'b0);
            for (int k = 0; k <= w_mem; k++) begin
                c = '0; c.iord = 1'b1;
                if (op == 6'h23) c.mem_read = 1'b1; else c.mem_write = 1'b1;
                c.timeout = (k < w_mem) && to_hit(k);
                push(k == w_mem, op, c, 1'b0, (k == w_mem) && (op == 6'h2B));
            end
            if (op == 6'h23) begin
                c = '0; c.reg_write = 1'b1; c.mem_to_reg = 2'd1;
                push(1'($urandom), op, c, 1'b0, 1'b1);
            end
        end else if (br_c) begin
            c = '0; c.alu_src_a = 1'b1; c.alu_op = (op == 6'h05) ? 4'd6 : 4'd3;
            c.pc_write_cond = 1'b1; c.pc_src = 2'd1; c.branch_ne = (op == 6'h05);
            push(1'($urandom), op, c, 1'b0, 1'b1);
        end else if (jmp_c) begin
            c = '0; c.pc_write = 1'b1; c.pc_src = 2'd2;
            if (op == 6'h03) begin
                c.reg_write = 1'b1; c.reg_dst = 2'd2; c.mem_to_reg = 2'd2;
            end
            push(1'($urandom), op, c, 1'b0, 1'b1);
        end
    endfunction

    // Play one modelled cycle: drive after the edge, check at the falling edge.
    task automatic run_one();
        step_t s;
        s = q.pop_front();
        mem_ready_i = s.ready;
        instr_op_i  = s.op;
        zero_i      = 1'($urandom);
        @(negedge clk_i);
        n_cmp++;
        assert (obs === s.exp) else begin
            n_bad++;
            $error("FAIL ctrl step=%0d op=%h state=%0d: observed %h expected %h",
                   step_no, s.op, state_o, obs, s.exp);
        end
`ifdef MC_PERF_CNT_EN
        n_cmp++;
        assert (cyc_cnt_o === m_cyc) else begin
            n_bad++;
            $error("FAIL cyc_cnt step=%0d: observed %0d expected %0d", step_no, cyc_cnt_o, m_cyc);
        end
        n_cmp++;
        assert (instr_cnt_o === m_instr) else begin
            n_bad++;
            $error("FAIL instr_cnt step=%0d: observed %0d expected %0d", step_no, instr_cnt_o, m_instr);
        end
`endif
        @(posedge clk_i);
        #1;
        if (!s.idle) m_cyc++;
        if (s.retire) m_instr++;
        step_no++;
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) run_one();
    endtask

    task automatic run_all();
        while (q.size() > 0) run_one();
    endtask

    task automatic check_reset(input string tag);
        n_cmp++;
        assert (obs === ctrl_t'(0)) else begin
            n_bad++;
            $error("FAIL %s outputs: observed %h expected 0", tag, obs);
        end
`ifdef MC_PERF_CNT_EN
        n_cmp++;
        assert ((cyc_cnt_o === 32'd0) && (instr_cnt_o === 32'd0)) else begin
            n_bad++;
            $error("FAIL %s perf: observed %0d/%0d expected 0/0", tag, cyc_cnt_o, instr_cnt_o);
        end
`endif
    endtask

    initial begin
        logic [5:0] op;
        int         r, wi, wm;
        rst_i = 1'b0; mem_ready_i = 1'b1; zero_i = 1'b0; instr_op_i = 6'h00;
        repeat (2) @(posedge clk_i);
        #1;
        check_reset("reset_hold");
        rst_i = 1'b1;
        push_idle();

        // R, LW, BEQ at zero wait, then one more IF cycle
        gen_instr(6'h00, 0, 0); gen_instr(6'h23, 0, 0); gen_instr(6'h04, 0, 0);
        run_all();
        gen_instr(6'h00, 1, 0);
        run_n(1);
`ifdef MC_PERF_CNT_EN
        n_cmp++;
        assert ((cyc_cnt_o === 32'd13) && (instr_cnt_o === 32'd3)) else begin
            n_bad++;
            $error("FAIL perf_three: observed cyc=%0d instr=%0d expected cyc=13 instr=3",
                   cyc_cnt_o, instr_cnt_o);
        end
`endif
        run_all();

        // LW with 3 memory waits, BNE, JAL, illegal opcode
        gen_instr(6'h23, 0, 3); gen_instr(6'h05, 0, 0);
        gen_instr(6'h03, 0, 0); gen_instr(6'h3F, 0, 0);
        run_all();

        // fetch stalled long enough to time out twice
        gen_instr(6'h00, 32, 0);
        run_all();

        // async reset in the middle of a store wait
        gen_instr(6'h2B, 0, 8);
        run_n(5);
        #2 rst_i = 1'b0;
        #1 check_reset("reset_async");
        q.delete();
        m_cyc = 0; m_instr = 0;
        @(posedge clk_i);
        #1;
        check_reset("reset_edge");
        rst_i = 1'b1;
        push_idle();
        gen_instr(6'h00, 16, 0);
        run_all();

        // randomized instruction stream
        for (int n = 0; n < 60; n++) begin
            r  = $urandom_range(0, 12);
            op = (r < 10) ? legal_ops[r] : ((r == 10) ? 6'h03 : 6'($urandom));
            wi = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 20) : $urandom_range(0, 2);
            wm = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 20) : $urandom_range(0, 3);
            gen_instr(op, wi, wm);
            run_all();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
